// File: rtl/alu_issue_unit.sv
// Queued ALU issue unit: in-order command FIFO feeding a registered result stage.
// Optional macro ALU_ISSUE_FLAGS_EN adds registered flag_z/flag_c/flag_v outputs.
module alu_issue_unit #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] ADD,
  output logic [WIDTH-1:0] SUB,
  output logic [WIDTH-1:0] AND,
  output logic [WIDTH-1:0] OR,
  output logic [31:0]      ALUControl,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;

  logic [1:0]       q_op [FIFO_DEPTH];
  logic [WIDTH-1:0] q_a  [FIFO_DEPTH];
  logic [WIDTH-1:0] q_b  [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;

  logic full, empty, push, pop;
  logic [1:0]       h_op;
  logic [WIDTH-1:0] h_a, h_b, h_add, h_sub;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // Ready comes from registered occupancy only, so a same-cycle pop never frees a full queue.
  assign cmd_ready = !full && !rst;
  assign push  = cmd_valid && cmd_ready;
  assign pop   = !empty && ((state == IDLE) || out_ready);

  assign h_op  = q_op[rd_ptr];
  assign h_a   = q_a[rd_ptr];
  assign h_b   = q_b[rd_ptr];
  assign h_add = h_a + h_b;
  assign h_sub = h_a - h_b;

`ifdef ALU_ISSUE_FLAGS_EN
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] h_sel;
  logic             h_c, h_v;

  assign sum_ext = {1'b0, h_a} + {1'b0, h_b};

  always_comb begin
    h_sel = h_add;
    h_c   = 1'b0;
    h_v   = 1'b0;
    case (h_op)
      2'd0: begin
        h_sel = h_add;
        h_c   = sum_ext[WIDTH];
        h_v   = (h_a[WIDTH-1] == h_b[WIDTH-1]) && (h_add[WIDTH-1] != h_a[WIDTH-1]);
      end
      2'd1: begin
        h_sel = h_sub;
        h_c   = (h_a < h_b);
        h_v   = (h_a[WIDTH-1] != h_b[WIDTH-1]) && (h_sub[WIDTH-1] != h_a[WIDTH-1]);
      end
      2'd2:    h_sel = h_a & h_b;
      default: h_sel = h_a | h_b;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr] <= cmd_op;
      q_a[wr_ptr]  <= cmd_a;
      q_b[wr_ptr]  <= cmd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      out_valid  <= 1'b0;
      ADD        <= '0;
      SUB        <= '0;
      AND        <= '0;
      OR         <= '0;
      ALUControl <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        state      <= HOLD;
        out_valid  <= 1'b1;
        ADD        <= h_add;
        SUB        <= h_sub;
        AND        <= h_a & h_b;
        OR         <= h_a | h_b;
        ALUControl <= {30'b0, h_op};
`ifdef ALU_ISSUE_FLAGS_EN
        flag_z     <= (h_sel == '0);
        flag_c     <= h_c;
        flag_v     <= h_v;
`endif
      end else if (state == HOLD && out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit (define ALU_ISSUE_FLAGS_EN to cover flags).
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, out_valid, out_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [31:0] ADD, SUB, AND, OR, ALUControl;
`ifdef ALU_ISSUE_FLAGS_EN
  logic        flag_z, flag_c, flag_v;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] qa[$], qb[$];
  logic [1:0]  qo[$];
  int          sent, recv;
  logic        stalled;
  logic [31:0] s_add, s_sub, s_ctl;

  always #5 clk = ~clk;

  alu_issue_unit #(.WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef ALU_ISSUE_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = '0; cmd_b = '0; out_ready = 1'b0;
    tick; tick;
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_ready", {31'b0, cmd_ready}, 0);
    chk("rst_add", ADD, 0);
    chk("rst_ctl", ALUControl, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, cmd_ready}, 1);

    // single command latency and results
    cmd_valid = 1'b1; cmd_a = 32'd1; cmd_b = 32'd2; cmd_op = 2'd0; out_ready = 1'b1;
    tick;
    cmd_valid = 1'b0;
    chk("lat_k_valid", {31'b0, out_valid}, 0);
    tick;
    chk("lat_k1_valid", {31'b0, out_valid}, 1);
    chk("basic_add", ADD, 32'd3);
    chk("basic_sub", SUB, 32'hFFFF_FFFF);
    chk("basic_and", AND, 32'd0);
    chk("basic_or", OR, 32'd3);
    chk("basic_ctl", ALUControl, 32'd0);
    tick;
    chk("basic_idle", {31'b0, out_valid}, 0);

    // fill output stage plus the whole queue while stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'(i % 4); cmd_a = 32'(i + 10); cmd_b = 32'(i);
      if (i == 4) chk("fill_ready_5th", {31'b0, cmd_ready}, 1);
      tick;
    end
    chk("full_ready", {31'b0, cmd_ready}, 0);
    chk("full_hold", {31'b0, out_valid}, 1);
    cmd_op = 2'd1; cmd_a = 32'd99; cmd_b = 32'd0;
    tick;
    cmd_valid = 1'b0;
    chk("full_still", {31'b0, cmd_ready}, 0);
    chk("stall_ctl", ALUControl, 0);
    chk("stall_add", ADD, 32'd10);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick;
      chk("drain_ctl", ALUControl, 32'(i % 4));
      chk("drain_add", ADD, 32'(2 * i + 10));
    end
    tick;
    chk("drain_empty", {31'b0, out_valid}, 0);

    // 20 commands with out_ready toggling, in-order scoreboard and stall stability
    sent = 0; recv = 0; stalled = 1'b0; s_add = '0; s_sub = '0; s_ctl = '0;
    for (int cyc = 0; cyc < 200 && recv < 20; cyc++) begin
      out_ready = (cyc % 2 == 1);
      cmd_valid = (sent < 20);
      cmd_op    = 2'(sent % 4);
      cmd_a     = 32'(sent * 37 + 5);
      cmd_b     = 32'(sent * 53) ^ 32'h0000_0F0F;
      #2;
      if (stalled) begin
        chk("stall_stable_add", ADD, s_add);
        chk("stall_stable_sub", SUB, s_sub);
        chk("stall_stable_ctl", ALUControl, s_ctl);
        chk("stall_stable_valid", {31'b0, out_valid}, 1);
      end
      if (out_valid && out_ready) begin
        if (qa.size() == 0) begin
          chk("sb_unexpected", 32'(recv), 32'hFFFF_FFFF);
        end else begin
          chk("sb_add", ADD, qa[0] + qb[0]);
          chk("sb_sub", SUB, qa[0] - qb[0]);
          chk("sb_and", AND, qa[0] & qb[0]);
          chk("sb_or", OR, qa[0] | qb[0]);
          chk("sb_ctl", ALUControl, {30'b0, qo[0]});
          void'(qa.pop_front()); void'(qb.pop_front()); void'(qo.pop_front());
        end
        recv++;
      end
      stalled = out_valid && !out_ready;
      s_add = ADD; s_sub = SUB; s_ctl = ALUControl;
      if (cmd_valid && cmd_ready) begin
        qa.push_back(cmd_a); qb.push_back(cmd_b); qo.push_back(cmd_op);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("sb_recv", 32'(recv), 32'd20);
    chk("sb_left", 32'(qa.size()), 32'd0);
    tick;
    chk("sb_idle", {31'b0, out_valid}, 0);

    // reset with three queued and one held command
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'(i); cmd_a = 32'(200 + i); cmd_b = 32'd1;
      tick;
    end
    chk("pre_rst_hold", {31'b0, out_valid}, 1);
    rst = 1'b1; cmd_a = 32'd555;
    tick;
    chk("mrst_valid", {31'b0, out_valid}, 0);
    chk("mrst_add", ADD, 0);
    chk("mrst_sub", SUB, 0);
    chk("mrst_and", AND, 0);
    chk("mrst_or", OR, 0);
    chk("mrst_ctl", ALUControl, 0);
    chk("mrst_ready", {31'b0, cmd_ready}, 0);
    rst = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("mrst_ready_after", {31'b0, cmd_ready}, 1);
    out_ready = 1'b1;
    tick; tick;
    chk("mrst_no_ghost", {31'b0, out_valid}, 0);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 32'd8; cmd_b = 32'd3;
    tick;
    cmd_valid = 1'b0;
    tick;
    chk("mrst_new_valid", {31'b0, out_valid}, 1);
    chk("mrst_new_ctl", ALUControl, 32'd1);
    chk("mrst_new_sub", SUB, 32'd5);
    tick;

`ifdef ALU_ISSUE_FLAGS_EN
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 32'h7FFF_FFFF; cmd_b = 32'd1;
    tick;
    cmd_op = 2'd1; cmd_a = 32'd5; cmd_b = 32'd5;
    tick;
    cmd_valid = 1'b0;
    chk("flag_ovf_add", ADD, 32'h8000_0000);
    chk("flag_ovf_v", {31'b0, flag_v}, 1);
    chk("flag_ovf_c", {31'b0, flag_c}, 0);
    chk("flag_ovf_z", {31'b0, flag_z}, 0);
    tick;
    chk("flag_sub_z", {31'b0, flag_z}, 1);
    chk("flag_sub_c", {31'b0, flag_c}, 0);
    chk("flag_sub_v", {31'b0, flag_v}, 0);
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
